// File: rtl/slv_arbiter.sv
// slv_arbiter: three-channel beat arbiter with burst ownership feeding one
// registered output stage. A burst owner keeps the grant until its length
// is exhausted or the channel is disabled.
// Build option: define SLV_ARB_RR_EN for round-robin tie-breaking among equal
// priorities. When it is undefined, ties go to channel 0, then 1, then 2.
module slv_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv0_req_i,
  input  logic [DATA_WIDTH-1:0] slv0_data_i,
  input  logic [1:0]            slv0_prio_i,
  input  logic [2:0]            slv0_len_i,
  input  logic                  slv0_en_i,
  output logic                  slv0_ack_o,
  input  logic                  slv1_req_i,
  input  logic [DATA_WIDTH-1:0] slv1_data_i,
  input  logic [1:0]            slv1_prio_i,
  input  logic [2:0]            slv1_len_i,
  input  logic                  slv1_en_i,
  output logic                  slv1_ack_o,
  input  logic                  slv2_req_i,
  input  logic [DATA_WIDTH-1:0] slv2_data_i,
  input  logic [1:0]            slv2_prio_i,
  input  logic [2:0]            slv2_len_i,
  input  logic                  slv2_en_i,
  output logic                  slv2_ack_o,
  output logic                  a2f_val_o,
  output logic [1:0]            a2f_id_o,
  output logic [DATA_WIDTH-1:0] a2f_data_o,
  input  logic                  f2a_rdy_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_owner;
  logic [1:0]            w_owner_nxt;
  logic [2:0]            r_remaining;
  logic [2:0]            w_remaining_nxt;
  logic                  r_val;
  logic [1:0]            r_id;
  logic [DATA_WIDTH-1:0] r_data;

  logic [2:0]            w_req;
  logic [2:0]            w_en;
  logic [2:0]            w_elig;
  logic [1:0]            w_prio [3];
  logic [2:0]            w_len  [3];
  logic [DATA_WIDTH-1:0] w_data [3];

  logic                  w_load;
  logic                  w_any;
  logic [1:0]            w_min_prio;
  logic [1:0]            w_start;
  logic [1:0]            w_ord  [3];
  logic [1:0]            w_win;
  logic                  w_cap;
  logic                  w_cap_g;
  logic [1:0]            w_sel;

`ifdef SLV_ARB_RR_EN
  logic [1:0]            r_rr_last;
  logic [1:0]            w_rr_nxt;
`endif

  // Gather the per-channel ports into indexable form.
  always_comb begin
    w_req     = {slv2_req_i, slv1_req_i, slv0_req_i};
    w_en      = {slv2_en_i, slv1_en_i, slv0_en_i};
    w_elig    = w_req & w_en;
    w_prio[0] = slv0_prio_i;
    w_prio[1] = slv1_prio_i;
    w_prio[2] = slv2_prio_i;
    w_len[0]  = slv0_len_i;
    w_len[1]  = slv1_len_i;
    w_len[2]  = slv2_len_i;
    w_data[0] = slv0_data_i;
    w_data[1] = slv1_data_i;
    w_data[2] = slv2_data_i;
  end

  // Winner search: lowest priority value among eligible channels, ties
  // resolved by scanning from the tie-break start channel.
  always_comb begin
    w_any      = |w_elig;
    w_min_prio = 2'd3;
    if (w_elig[0] && (w_prio[0] < w_min_prio)) w_min_prio = w_prio[0];
    if (w_elig[1] && (w_prio[1] < w_min_prio)) w_min_prio = w_prio[1];
    if (w_elig[2] && (w_prio[2] < w_min_prio)) w_min_prio = w_prio[2];
`ifdef SLV_ARB_RR_EN
    w_start = (r_rr_last == 2'd2) ? 2'd0 : r_rr_last + 2'd1;
`else
    w_start = 2'd0;
`endif
    case (w_start)
      2'd1:    begin w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0; end
      2'd2:    begin w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1; end
      default: begin w_ord[0] = 2'd0; w_ord[1] = 2'd1; w_ord[2] = 2'd2; end
    endcase
    if (w_elig[w_ord[0]] && (w_prio[w_ord[0]] == w_min_prio))      w_win = w_ord[0];
    else if (w_elig[w_ord[1]] && (w_prio[w_ord[1]] == w_min_prio)) w_win = w_ord[1];
    else                                                          w_win = w_ord[2];
  end

  // Next-state, capture decision and burst bookkeeping.
  always_comb begin
    w_load          = !r_val || f2a_rdy_i;
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_remaining_nxt = r_remaining;
    w_cap           = 1'b0;
    w_sel           = r_owner;
`ifdef SLV_ARB_RR_EN
    w_rr_nxt        = r_rr_last;
`endif
    case (r_state)
      IDLE: begin
        if (w_load && w_any) begin
          w_cap           = 1'b1;
          w_sel           = w_win;
          w_owner_nxt     = w_win;
          w_remaining_nxt = w_len[w_win];
`ifdef SLV_ARB_RR_EN
          w_rr_nxt        = w_win;
`endif
          if (w_len[w_win] != 3'd0) w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (!w_en[r_owner]) begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = 3'd0;
        end else if (w_req[r_owner] && w_load) begin
          w_cap           = 1'b1;
          w_remaining_nxt = r_remaining - 3'd1;
          if (r_remaining == 3'd1) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_cap_g    = w_cap && !rst_i;
    slv0_ack_o = w_cap_g && (w_sel == 2'd0);
    slv1_ack_o = w_cap_g && (w_sel == 2'd1);
    slv2_ack_o = w_cap_g && (w_sel == 2'd2);
  end

  // FSM and burst registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

`ifdef SLV_ARB_RR_EN
  // Last burst-start winner, seeds the next tie-break scan.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rr_last <= 2'd2;
    else       r_rr_last <= w_rr_nxt;
  end
`endif

  // Output stage: load on capture, hold while stalled, drop valid when drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_val  <= 1'b0;
      r_id   <= '0;
      r_data <= '0;
    end else if (w_cap) begin
      r_val  <= 1'b1;
      r_id   <= w_sel;
      r_data <= w_data[w_sel];
    end else if (f2a_rdy_i) begin
      r_val  <= 1'b0;
    end
  end

  assign a2f_val_o  = r_val;
  assign a2f_id_o   = r_id;
  assign a2f_data_o = r_data;

endmodule

// File: tb/tb_slv_arbiter.sv
// Testbench for slv_arbiter: reference model predicts acks and output beats,
// expected beats queued and checked by an independent output monitor.
module tb_slv_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  en  = '0;
  logic [1:0]  prio [3];
  logic [2:0]  len  [3];
  logic [31:0] dat  [3];
  logic        rdy = 1'b0;
  logic        ack0, ack1, ack2;
  logic        val;
  logic [1:0]  id;
  logic [31:0] data;

  int checks = 0;
  int errors = 0;

  logic [33:0] q[$];
  bit m_val   = 1'b0;
  int m_owner = -1;
  int m_left  = 0;
  int m_rr    = 2;

  always #5 clk = ~clk;

  slv_arbiter #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_req_i(req[0]), .slv0_data_i(dat[0]), .slv0_prio_i(prio[0]),
    .slv0_len_i(len[0]), .slv0_en_i(en[0]), .slv0_ack_o(ack0),
    .slv1_req_i(req[1]), .slv1_data_i(dat[1]), .slv1_prio_i(prio[1]),
    .slv1_len_i(len[1]), .slv1_en_i(en[1]), .slv1_ack_o(ack1),
    .slv2_req_i(req[2]), .slv2_data_i(dat[2]), .slv2_prio_i(prio[2]),
    .slv2_len_i(len[2]), .slv2_en_i(en[2]), .slv2_ack_o(ack2),
    .a2f_val_o(val), .a2f_id_o(id), .a2f_data_o(data),
    .f2a_rdy_i(rdy)
  );

  // Best eligible channel: smallest (priority, distance from tie-break start).
  function automatic int pick();
    int best = -1;
    int bestkey = 1000;
    int start;
`ifdef SLV_ARB_RR_EN
    start = (m_rr + 1) % 3;
`else
    start = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      if (req[i] && en[i]) begin
        int key = int'(prio[i]) * 3 + (i - start + 3) % 3;
        if (key < bestkey) begin
          bestkey = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // One clock: called 1 time unit after a rising edge with inputs applied.
  task automatic step();
    int cap = -1;
    logic [2:0] exp_ack;
    logic [2:0] act_ack;
    bit load;
    #3;
    if (!rst) begin
      load = !m_val || rdy;
      if (m_owner < 0) begin
        if (load) begin
          int w = pick();
          if (w >= 0) begin
            cap = w;
            m_rr = w;
            if (len[w] != 0) begin
              m_owner = w;
              m_left = int'(len[w]);
            end
          end
        end
      end else if (!en[m_owner]) begin
        m_owner = -1;
      end else if (req[m_owner] && load) begin
        cap = m_owner;
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
      checks++;
      if (val !== m_val) begin
        errors++;
        $display("FAIL valid act=%b exp=%b t=%0t", val, m_val, $time);
      end
    end
    exp_ack = (cap >= 0) ? (3'b001 << cap) : 3'b000;
    act_ack = {ack2, ack1, ack0};
    checks++;
    if (act_ack !== exp_ack) begin
      errors++;
      $display("FAIL ack act=%b exp=%b t=%0t", act_ack, exp_ack, $time);
    end
    if (!rst) begin
      if (cap >= 0) q.push_back({cap[1:0], dat[cap]});
      if (cap >= 0) m_val = 1'b1;
      else if (rdy) m_val = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    step();
    checks++;
    if (val !== 1'b0 || id !== 2'd0 || data !== 32'd0) begin
      errors++;
      $display("FAIL reset_out act=%b/%0d/%h exp=0/0/0", val, id, data);
    end
    step();
    rst = 1'b0;
    q.delete();
    m_val = 1'b0;
    m_owner = -1;
    m_left = 0;
    m_rr = 2;
  endtask

  task automatic set_all(input logic [1:0] p, input logic [2:0] l);
    for (int i = 0; i < 3; i++) begin
      prio[i] = p;
      len[i] = l;
      dat[i] = $urandom;
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < 3; i++) dat[i] = $urandom;
  endtask

  // Output monitor: presented beat must match the oldest expected beat; it
  // is retired only when the downstream accepts it.
  always @(negedge clk) begin
    if (!rst && val) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected act=%0d/%h exp=none", id, data);
      end else begin
        if ({id, data} !== q[0]) begin
          errors++;
          $display("FAIL beat act=%0d/%h exp=%0d/%h", id, data, q[0][33:32], q[0][31:0]);
        end
        if (rdy) void'(q.pop_front());
      end
    end
  end

  initial begin
    set_all(2'd0, 3'd0);
    do_reset();

    // Equal priority, single beats, all requesting.
    en = 3'b111; req = 3'b111; rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin new_data(); step(); end

    // Channel 2 has strictly best priority.
    prio[0] = 2'd3; prio[1] = 2'd3; prio[2] = 2'd0;
    for (int c = 0; c < 6; c++) begin new_data(); step(); end

    // Channel 1 four-beat burst; channel 0 arrives mid-burst.
    set_all(2'd0, 3'd0);
    len[1] = 3'd3; req = 3'b010;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) req = 3'b011;
      new_data(); step();
    end

    // Downstream stall for five cycles then release.
    set_all(2'd1, 3'd0); req = 3'b111;
    for (int c = 0; c < 9; c++) begin
      rdy = (c < 1 || c > 5);
      new_data(); step();
    end

    // Eight-beat burst on channel 0 abandoned by disabling it.
    rdy = 1'b1; set_all(2'd1, 3'd0);
    prio[0] = 2'd0; len[0] = 3'd7; req = 3'b000;
    step(); step();
    req = 3'b011;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) en[0] = 1'b0;
      new_data(); step();
    end
    en = 3'b111;

    // Reset in the middle of a burst with a held beat.
    set_all(2'd0, 3'd7); req = 3'b111; rdy = 1'b1;
    step(); step(); rdy = 1'b0; step();
    do_reset();
    set_all(2'd0, 3'd0); req = 3'b111; rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin new_data(); step(); end

    // Randomized traffic including occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        en[i]   = ($urandom_range(0, 15) != 0);
        prio[i] = 2'($urandom_range(0, 3));
        len[i]  = 3'($urandom_range(0, 7));
        dat[i]  = $urandom;
      end
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    // Drain and confirm every expected beat was delivered.
    req = 3'b000; rdy = 1'b1;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slv_arbiter.md
SLV_ARBITER -- requirements
Module: slv_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of channel and output data.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 slvN_req_i  input  1  (N=0,1,2) channel N has a beat on slvN_data_i.
REQ-005 slvN_data_i  input  DATA_WIDTH  channel N beat data.
REQ-006 slvN_prio_i  input  2  channel N priority from control registers; 0 highest, 3 lowest.
REQ-007 slvN_len_i  input  3  channel N burst length from control registers; beats = len+1.
REQ-008 slvN_en_i  input  1  channel N enable from control registers.
REQ-009 slvN_ack_o  output  1  combinational; beat on channel N accepted this cycle.
REQ-010 a2f_val_o  output  1  registered; output beat valid.
REQ-011 a2f_id_o  output  2  registered; source channel of output beat (0..2).
REQ-012 a2f_data_o  output  DATA_WIDTH  registered; output beat data.
REQ-013 f2a_rdy_i  input  1  downstream formatter accepts output beat when high with a2f_val_o.

Function
REQ-014 Channel N eligible when slvN_req_i=1 and slvN_en_i=1.
REQ-015 Load condition: load = !a2f_val_o || f2a_rdy_i; beats captured only when load=1.
REQ-016 On capture from channel N: slvN_ack_o=1 that cycle; next cycle a2f_val_o=1, a2f_id_o=N, a2f_data_o=slvN_data_i; single-cycle latency.
REQ-017 a2f_val_o, a2f_id_o, a2f_data_o held stable while a2f_val_o=1 and f2a_rdy_i=0.
REQ-018 a2f_val_o cleared when f2a_rdy_i=1 and no capture that cycle; back-to-back beats with no bubble when capture coincides with f2a_rdy_i=1.
REQ-019 At most one slvN_ack_o high per cycle; ack never asserted for an ineligible channel.
REQ-020 FSM states IDLE and BURST; reset state IDLE.
REQ-021 IDLE, load=1, any eligible: winner = eligible channel with lowest prio value, ties per REQ-029; capture winner; owner=winner; remaining=winner len_i sampled this cycle; go BURST if remaining>0 else stay IDLE.
REQ-022 IDLE, load=0 or none eligible: no capture, stay IDLE.
REQ-023 BURST, load=1, owner eligible: capture owner, remaining decrements; go IDLE when remaining was 1.
REQ-024 BURST, owner req_i=0 and en_i=1: no capture, stay BURST, no other channel granted.
REQ-025 BURST, owner en_i=0: no capture, go IDLE next cycle; remaining beats abandoned.
REQ-026 len_i or prio_i changes during BURST have no effect until next burst start.
REQ-027 len_i=0 gives single-beat bursts; len_i=7 gives 8 beats.

Reset
REQ-028 rst_i=1 at rising edge: a2f_val_o=0, a2f_id_o=0, a2f_data_o=0, FSM=IDLE, remaining=0, owner=0, rr_last=2; slvN_ack_o=0 during rst_i=1; reset mid-burst discards held beat and burst.

Configuration
REQ-029 Macro SLV_ARB_RR_EN defined: priority ties broken round-robin, search order starts at channel after rr_last (mod 3); rr_last=winner on each burst start; undefined: ties broken fixed, channel 0 > 1 > 2, no rr_last register.

Verification
REQ-030 All en=1, prio=0, len=0, all req held, f2a_rdy_i=1: SLV_ARB_RR_EN ids 0,1,2,0,...; undefined ids 0,0,0,...
REQ-031 slv2 prio=0, slv0/slv1 prio=3, all req, len=0: only slv2 acked while req held.
REQ-032 slv1 len=3, sole requester, f2a_rdy_i=1: 4 acks on consecutive cycles, id=1; slv0 request raised after beat 2 not granted until burst ends.
REQ-033 Output valid with f2a_rdy_i=0 for 5 cycles: a2f_* stable, no slvN_ack_o; first cycle f2a_rdy_i=1 next beat captured without bubble.
REQ-034 slv0 len=7 burst, slv0_en_i dropped after beat 3: no further slv0 ack, FSM IDLE next cycle, pending slv1 granted after.
REQ-035 rst_i=1 mid-burst with a2f_val_o=1: next cycle a2f_val_o=0, id=0, data=0; first grant after reset (RR build, ties) goes to slv0.
